// File: rtl/hci_package.sv
// rtl/hci_package.sv - shared HCI widths and memory-target state type
//
// Default interface widths used by the memory-side HCI ports and the
// two-state grant-stall FSM encoding of the single-bank memory target.
package hci_package;

  localparam int unsigned DEFAULT_AW = 32;
  localparam int unsigned DEFAULT_DW = 32;
  localparam int unsigned DEFAULT_BW = 8;
  localparam int unsigned DEFAULT_UW = 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } hci_mem_target_state_t;

endpackage

// File: rtl/hci_mem_target_bank_stall_fsm.sv
// rtl/hci_mem_target_bank_stall_fsm.sv - programmable grant-stall FSM for the memory target
//
// Inserts stall_cycles_i wait states in front of every grant.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   req             request from the interconnect
//   stall_cycles_i  wait states per grant, sampled when a request leaves IDLE
//   gnt             combinational grant
module hci_mem_target_stall_fsm
  import hci_package::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req,
  input  logic [3:0] stall_cycles_i,
  output logic       gnt
);

  hci_mem_target_state_t state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt = req && (stall_cycles_i == 4'd0);
        // The raise cycle counts as the first wait state, hence S-1.
        if (req && (stall_cycles_i != 4'd0)) begin
          cnt_d   = stall_cycles_i - 4'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          // An abandoned request forfeits its progress; the next one
          // pays the full stall again.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          gnt     = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/hci_mem_target_bank.sv
// rtl/hci_mem_target_bank.sv - single-bank HCI memory target with grant stalling
//
// Terminates one memory-side HCI port. Stores N_WORDS words of {user,data},
// applies byte-enabled writes, returns read data and id one cycle after each
// req&gnt handshake, and counts handshakes.
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   mem_req/add/wen/be/data/user/id     request (wen=1 read, wen=0 write)
//   mem_gnt                             grant, from the stall FSM
//   mem_r_data/r_user/r_id              response, valid the cycle after a handshake
//   stall_cycles_i                      wait states before each grant
//   access_cnt_o                        saturating handshake count
module hci_mem_target_bank
  import hci_package::*;
#(
  parameter int unsigned AW      = hci_package::DEFAULT_AW,
  parameter int unsigned DW      = hci_package::DEFAULT_DW,
  parameter int unsigned BW      = hci_package::DEFAULT_BW,
  parameter int unsigned UW      = hci_package::DEFAULT_UW,
  parameter int unsigned IW      = 20,
  parameter int unsigned N_WORDS = 1024,
  // A zero-width user field is carried as one unused bit.
  localparam int unsigned UWP    = (UW > 0) ? UW : 1,
  localparam int unsigned NB     = DW / BW
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           mem_req,
  input  logic [AW-1:0]  mem_add,
  input  logic           mem_wen,
  input  logic [NB-1:0]  mem_be,
  input  logic [DW-1:0]  mem_data,
  input  logic [UWP-1:0] mem_user,
  input  logic [IW-1:0]  mem_id,
  output logic           mem_gnt,
  output logic [DW-1:0]  mem_r_data,
  output logic [UWP-1:0] mem_r_user,
  output logic [IW-1:0]  mem_r_id,
  input  logic [3:0]     stall_cycles_i,
  output logic [31:0]    access_cnt_o
);

  localparam int unsigned IDXW = $clog2(N_WORDS);

  logic [DW+UWP-1:0] mem_q [N_WORDS];
  logic [IDXW-1:0]   idx;
  logic              hs;
  logic              unused_add;

  // Bits outside the word index are ignored, so addresses alias.
  assign idx        = mem_add[IDXW+1:2];
  assign unused_add = ^{mem_add[AW-1:IDXW+2], mem_add[1:0]};
  assign hs         = mem_req & mem_gnt;

  hci_mem_target_stall_fsm i_stall_fsm (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req            (mem_req),
    .stall_cycles_i (stall_cycles_i),
    .gnt            (mem_gnt)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (hs && !mem_wen) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (mem_be[b]) mem_q[idx][b*BW +: BW] <= mem_data[b*BW +: BW];
      end
      if ((UW > 0) && (|mem_be)) mem_q[idx][DW +: UWP] <= mem_user;
    end
  end

  // Writes refresh only r_id; read data stays from the last read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_r_data <= '0;
      mem_r_user <= '0;
      mem_r_id   <= '0;
    end else if (hs) begin
      mem_r_id <= mem_id;
      if (mem_wen) {mem_r_user, mem_r_data} <= mem_q[idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      access_cnt_o <= 32'd0;
    end else if (hs && (access_cnt_o != 32'hFFFF_FFFF)) begin
      access_cnt_o <= access_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_hci_mem_target_bank.sv
// tb/tb_hci_mem_target_bank.sv - self-checking bench for hci_mem_target_bank
module tb_hci_mem_target_bank;

  localparam int AW = 32, DW = 32, BW = 8, UW = 4, IW = 8, NW = 1024, NB = DW / BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_req, mem_wen, mem_gnt;
  logic [AW-1:0] mem_add;
  logic [NB-1:0] mem_be;
  logic [DW-1:0] mem_data, mem_r_data;
  logic [UW-1:0] mem_user, mem_r_user;
  logic [IW-1:0] mem_id, mem_r_id;
  logic [3:0]    stall;
  logic [31:0]   access_cnt;

  always #5 clk = ~clk;

  hci_mem_target_bank #(
    .AW(AW), .DW(DW), .BW(BW), .UW(UW), .IW(IW), .N_WORDS(NW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mem_req        (mem_req),
    .mem_add        (mem_add),
    .mem_wen        (mem_wen),
    .mem_be         (mem_be),
    .mem_data       (mem_data),
    .mem_user       (mem_user),
    .mem_id         (mem_id),
    .mem_gnt        (mem_gnt),
    .mem_r_data     (mem_r_data),
    .mem_r_user     (mem_r_user),
    .mem_r_id       (mem_r_id),
    .stall_cycles_i (stall),
    .access_cnt_o   (access_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: word array indexed by byte address / 4 modulo depth.
  logic [UW+DW-1:0] model_mem [NW];
  logic [DW-1:0]    exp_rdata;
  logic [UW-1:0]    exp_ruser;
  logic [IW-1:0]    exp_rid;
  longint unsigned  exp_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_req = 1'b0;
    step();
  endtask

  // Raise a request at the current cycle; expect gnt exactly s cycles later,
  // then check the response in the following cycle. req stays high on return.
  task automatic access(input bit rd, input logic [AW-1:0] addr, input logic [NB-1:0] be,
                        input logic [DW-1:0] d, input logic [UW-1:0] u,
                        input logic [IW-1:0] id, input int s);
    int               idx;
    logic [UW+DW-1:0] w;
    stall    = 4'(s);
    mem_req  = 1'b1;
    mem_wen  = rd;
    mem_add  = addr;
    mem_be   = be;
    mem_data = d;
    mem_user = u;
    mem_id   = id;
    for (int c = 0; c <= s; c++) begin
      @(negedge clk);
      check($sformatf("gnt s=%0d c=%0d", s, c), 64'(mem_gnt), 64'(c == s));
      if (c < s) step();
    end
    step();
    idx = int'((addr / 4) % NW);
    exp_rid = id;
    if (exp_cnt < 64'hFFFF_FFFF) exp_cnt++;
    if (rd) begin
      {exp_ruser, exp_rdata} = model_mem[idx];
    end else begin
      w = model_mem[idx];
      for (int b = 0; b < NB; b++)
        if (be[b]) w[b*BW +: BW] = d[b*BW +: BW];
      if (be != 0) w[DW +: UW] = u;
      model_mem[idx] = w;
    end
    check("r_id", 64'(mem_r_id), 64'(exp_rid));
    check("r_data", 64'(mem_r_data), 64'(exp_rdata));
    check("r_user", 64'(mem_r_user), 64'(exp_ruser));
    check("access_cnt", 64'(access_cnt), exp_cnt);
  endtask

  initial begin
    logic [31:0] r;
    int          s;
    rst_n = 1'b0;
    mem_req = 1'b0; mem_wen = 1'b1; mem_add = '0; mem_be = '0;
    mem_data = '0; mem_user = '0; mem_id = '0; stall = 4'd0;
    exp_rdata = '0; exp_ruser = '0; exp_rid = '0; exp_cnt = 0;
    step(); step();
    check("reset r_data", 64'(mem_r_data), 64'd0);
    check("reset r_user", 64'(mem_r_user), 64'd0);
    check("reset r_id", 64'(mem_r_id), 64'd0);
    check("reset access_cnt", 64'(access_cnt), 64'd0);
    rst_n = 1'b1;
    mem_req = 1'b1;
    #1;
    check("idle gnt s=0", 64'(mem_gnt), 64'd1);
    mem_req = 1'b0;
    step();

    // Give every word the random traffic touches a defined value.
    for (int i = 0; i < 16; i++) access(1'b0, AW'(i * 4), '1, $urandom(), UW'($urandom()), IW'(i), 0);
    idle();

    // Full write then read at word 5.
    access(1'b0, 32'd20, 4'b1111, 32'hDEAD_BEEF, 4'h5, 8'd3, 0);
    access(1'b1, 32'd20, 4'b0000, 32'h0, 4'h0, 8'd7, 0);
    check("read word5", 64'(mem_r_data), 64'hDEAD_BEEF);
    check("read id7", 64'(mem_r_id), 64'd7);
    idle();

    // Partial write with be=0101.
    access(1'b0, 32'd20, 4'b0101, 32'h1122_3344, 4'hA, 8'd9, 0);
    access(1'b1, 32'd20, 4'b0000, 32'h0, 4'h0, 8'd10, 0);
    check("partial merge", 64'(mem_r_data), 64'hDE22_BE44);
    idle();

    // S=3, back-to-back: second request stalled again.
    access(1'b1, 32'd20, 4'b0000, 32'h0, 4'h0, 8'd11, 3);
    access(1'b1, 32'd8, 4'b0000, 32'h0, 4'h0, 8'd12, 3);
    idle();

    // S=4 aborted in the second wait cycle, then full stall again.
    stall = 4'd4; mem_req = 1'b1; mem_wen = 1'b1; mem_add = 32'd12; mem_id = 8'd13;
    @(negedge clk); check("abort gnt c0", 64'(mem_gnt), 64'd0);
    step();
    @(negedge clk); check("abort gnt c1", 64'(mem_gnt), 64'd0);
    step();
    mem_req = 1'b0;
    @(negedge clk); check("abort gnt c2", 64'(mem_gnt), 64'd0);
    step();
    check("abort no count", 64'(access_cnt), exp_cnt);
    check("abort r_id held", 64'(mem_r_id), 64'(exp_rid));
    access(1'b1, 32'd12, 4'b0000, 32'h0, 4'h0, 8'd14, 4);
    idle();

    // Aliasing modulo N_WORDS*4.
    access(1'b0, 32'h0000_1008, 4'b1111, 32'hCAFE_F00D, 4'h3, 8'd15, 0);
    access(1'b1, 32'h0000_0008, 4'b0000, 32'h0, 4'h0, 8'd16, 0);
    check("alias read", 64'(mem_r_data), 64'hCAFE_F00D);
    idle();

    // Randomized traffic over words 0..15 with random high address bits.
    for (int n = 0; n < 80; n++) begin
      r = $urandom();
      s = $urandom_range(0, 3);
      access(1'($urandom()), (r & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2),
             NB'($urandom()), $urandom(), UW'($urandom()), IW'($urandom()), s);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();

    // Reset during WAIT with S=5.
    stall = 4'd5; mem_req = 1'b1; mem_wen = 1'b0; mem_add = 32'd16; mem_be = '1; mem_id = 8'd99;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("mid-reset r_data", 64'(mem_r_data), 64'd0);
    check("mid-reset r_id", 64'(mem_r_id), 64'd0);
    check("mid-reset access_cnt", 64'(access_cnt), 64'd0);
    check("mid-reset gnt", 64'(mem_gnt), 64'd0);
    mem_req = 1'b0;
    step();
    rst_n = 1'b1;
    exp_rdata = '0; exp_ruser = '0; exp_rid = '0; exp_cnt = 0;
    step();
    access(1'b1, 32'd16, 4'b0000, 32'h0, 4'h0, 8'd42, 5);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
